// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and default operand width for the HI/LO mul/div sequencer
package muldiv_pkg;
  localparam int W_DEF = 32;
  typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request and HI/LO result bundle between the pipeline and the mul/div sequencer
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::W_DEF
);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic mf_req;
  logic busy;
  logic stall;
  logic done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master(output start, op, rs_val, rt_val, mf_req, input busy, stall, done, hi_out, lo_out);
  modport slave(input start, op, rs_val, rt_val, mf_req, output busy, stall, done, hi_out, lo_out);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int WIDTH = muldiv_pkg::W_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum, diff;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // remainder bit shifted out of the pair becomes the subtract's extra top bit
    diff = {acc[2*WIDTH-1], acc[2*WIDTH-2:WIDTH-1]} - {1'b0, operand};
    acc_next = div_mode ? (diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                        : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative HI/LO mul/div sequencer; define MUL_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = W_DEF,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  state_t state;
  logic [2*WIDTH-1:0] acc, acc_nx, mul_acc, prod;
  logic [WIDTH-1:0] mcand, rs_mag, rt_mag, hi, lo, fix_hi, fix_lo;
  logic [CNT_W-1:0] cnt;
  logic neg, dneg, mul_op, done, busy, sgn, rs_neg, rt_neg, last, early;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .operand(mcand),
    .div_mode(state == S_DIV),
    .acc_next(acc_nx)
  );
  always_comb begin
    sgn = bus.op == OP_MULT || bus.op == OP_DIV;
    rs_neg = sgn & bus.rs_val[WIDTH-1];
    rt_neg = sgn & bus.rt_val[WIDTH-1];
    rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;
    prod = neg ? -acc : acc;
    fix_hi = mul_op ? prod[2*WIDTH-1:WIDTH] : dneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_lo = mul_op ? prod[WIDTH-1:0] : neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    last = cnt == CNT_W'(WIDTH - 1);
  end
`ifdef MUL_EARLY_OUT_EN
  logic [CNT_W-1:0] rem;
  always_comb begin
    rem = CNT_W'(WIDTH - 1) - cnt;
    early = (acc_nx & ~({(2*WIDTH){1'b1}} << rem)) == '0;
    mul_acc = acc_nx >> rem;
  end
`else
  assign early = 1'b0;
  assign mul_acc = acc_nx;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      neg <= 1'b0;
      dneg <= 1'b0;
      mul_op <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          cnt <= '0;
          mul_op <= !bus.op[1];
          neg <= rs_neg ^ rt_neg;
          dneg <= rs_neg;
          mcand <= bus.op[1] ? rt_mag : rs_mag;
          acc <= {{WIDTH{1'b0}}, bus.op[1] ? rs_mag : rt_mag};
          state <= bus.op[1] ? S_DIV : S_MUL;
          // divide by zero: raw dividend to HI, all ones to LO, no sign fix
          if (bus.op[1] && bus.rt_val == '0) begin
            neg <= 1'b0;
            dneg <= 1'b0;
            acc <= {bus.rs_val, {WIDTH{1'b1}}};
            state <= S_FIX;
          end
        end
        S_MUL: begin
          acc <= mul_acc;
          cnt <= cnt + 1'b1;
          if (last || early) state <= S_FIX;
        end
        S_DIV: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign busy = state != S_IDLE;
  assign bus.busy = busy;
  assign bus.stall = busy & (bus.start | bus.mf_req);
  assign bus.done = done;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core.
- Sits in EX beside the ALU and accepts mult/multu/div/divu from the EX stage.
- Runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles.
- Raises stall to the hazard unit while busy, and when an mfhi/mflo would read stale HI/LO.

Parameters:
- WIDTH, 32, operand width; also the number of iteration cycles.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  EX holds a mult/multu/div/divu this cycle.
- op  input  2  0=mult, 1=multu, 2=div, 3=divu.
- rs_val  input  WIDTH  multiplicand or dividend (forwarded value).
- rt_val  input  WIDTH  multiplier or divisor (forwarded value).
- mf_req  input  1  EX holds mfhi or mflo.
- busy  output  1  sequencer is not IDLE.
- stall  output  1  freeze PC, IF/ID and ID/EX this cycle.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, hi_out=0, lo_out=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation aborts the operation and discards the partial result.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1:
  - Capture op and operand magnitudes. For signed ops (mult, div), a negative operand is two's-complement negated; the result sign and the dividend sign are latched.
  - Go to MUL (op 0/1) or DIV (op 2/3); counter=0.
- IDLE with start=1, op 2/3 and rt_val=0: divide by zero. Go directly to FIX with result lo=all ones, hi=rs_val (raw value).
- MUL:
  - Each edge: if multiplier LSB=1, add the multiplicand to the upper half of a 2*WIDTH accumulator, keeping the carry (WIDTH+1-bit add).
  - Shift the accumulator right by 1.
  - At counter==WIDTH-1, go to FIX; otherwise increment the counter.
- DIV:
  - Each edge: shift the remainder:quotient pair left by 1.
  - Trial-subtract the divisor, using a WIDTH+1-bit subtract. If non-negative, keep the difference and set quotient LSB=1.
  - At counter==WIDTH-1, go to FIX.
- FIX:
  - Apply the sign. mult: negate the full 2*WIDTH product if the result sign is set. div: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Write hi_out/lo_out, pulse done=1, go to IDLE.
- Latency: the start-sampling edge is edge 0. HI/LO are valid after edge WIDTH+1, i.e. 34 edges for WIDTH=32. Divide by zero takes 2 edges.
- busy=1 in MUL, DIV and FIX.
- stall = busy & (start | mf_req) (combinational). Non-muldiv instructions are not stalled while busy.
- start while busy: ignored; stall holds the instruction in EX until IDLE, then it is accepted.
- mf_req in IDLE: no stall; hi_out/lo_out are stable. On the done cycle hi/lo already hold the new result and stall=0.
- start and mf_req together: not legal (same EX slot). If both are asserted, start wins.
- hi_out/lo_out change only at the FIX edge or on reset.

Optional Feature:
- MUL_EARLY_OUT_EN defined:
  - In MUL, if the remaining unshifted multiplier bits are all zero, skip to FIX. The accumulator is aligned by the remaining shift count in one step.
  - Example: multu 5*3 completes after edge 3 (2 multiplier bits).
  - Divide latency is unchanged.
- Undefined: MUL always takes WIDTH iterations. Results are identical in both builds.

Decomposition:
- muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encodings S_IDLE, S_MUL, S_DIV, S_FIX;
  - the default WIDTH constant.
- Sub-module muldiv_step (combinational): one shift-add or one restore-subtract iteration. Inputs: accumulator, operand, mode. Output: next accumulator. Instantiated once.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=7 -> after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; busy high for exactly 33 cycles.
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- divu 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234 after 2 edges.
- mf_req asserted 3 cycles after mult start -> stall=1 each cycle until done. Then mf_req with stall=0, and hi/lo equal the new result.
- rst pulsed low at iteration 10 of a div -> asynchronously hi=lo=0, busy=0. A following multu 5*3 gives lo=15, hi=0.
